// File: rtl/iot_output_pkg.sv
// Shared definitions for the IoT output PIO: register addresses and pulse FSM states.
package iot_output_pkg;

   localparam logic [2:0] ADDR_DATA  = 3'd0;
   localparam logic [2:0] ADDR_SET   = 3'd1;
   localparam logic [2:0] ADDR_CLEAR = 3'd2;
   localparam logic [2:0] ADDR_PLEN  = 3'd3;
   localparam logic [2:0] ADDR_TRIG  = 3'd4;
   localparam logic [2:0] ADDR_STAT  = 3'd5;

   typedef enum logic {IDLE = 1'b0, PULSE = 1'b1} pulse_state_t;

endpackage

// File: rtl/iot_pulse_timer.sv
// One-shot pulse timer: a load/decrement counter that stays busy for
// max(len,1) cycles after a start request and flags done on its final cycle.
module iot_pulse_timer
   import iot_output_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_start,
   input  logic [CNT_W-1:0] i_len,
   output logic             o_busy,
   output logic             o_done
);

   pulse_state_t     r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

   // State and counter registers; reset aborts any running pulse.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next state: a zero length still yields a one-cycle pulse, so the
   // counter is loaded with max(len,1)-1 and the pulse ends when it hits 0.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         IDLE: begin
            if (i_start) begin
               w_state_nxt = PULSE;
               w_cnt_nxt   = (i_len == '0) ? '0 : i_len - CNT_W'(1);
            end
         end
         PULSE: begin
            if (r_cnt == '0) w_state_nxt = IDLE;
            else             w_cnt_nxt   = r_cnt - CNT_W'(1);
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign o_busy = (r_state == PULSE);
   assign o_done = o_busy && (r_cnt == '0);

endmodule

// File: rtl/iot_output_pio.sv
// Avalon-MM output PIO with a timed one-shot inversion pulse.
// out_port = DATA register XOR the active pulse mask.
// Optional macro IOT_OUTPUT_PIO_BITSET_EN builds the atomic SET/CLEAR
// registers at addresses 1/2; without it those addresses are reserved.
module iot_output_pio
   import iot_output_pkg::*;
#(
   parameter int               DATA_W    = 4,
   parameter int               CNT_W     = 16,
   parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [2:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic [DATA_W-1:0] out_port,
   output logic              pulse_busy
);

   logic [DATA_W-1:0] r_data;
   logic [CNT_W-1:0]  r_plen;
   logic [DATA_W-1:0] r_mask;

   logic              w_wr;
   logic [DATA_W-1:0] w_wd_data;
   logic [CNT_W-1:0]  w_wd_cnt;
   logic              w_start;
   logic              w_busy;
   logic              w_done;
   logic [31:0]       w_rd;
   logic              w_unused_wd;

   assign w_wr        = chipselect & ~write_n;
   assign w_wd_data   = writedata[DATA_W-1:0];
   assign w_wd_cnt    = writedata[CNT_W-1:0];
   assign w_unused_wd = ^writedata;

   // A trigger only starts a pulse from idle; triggers mid-pulse are dropped.
   assign w_start = w_wr && (address == ADDR_TRIG) && (|w_wd_data) && !w_busy;

   // Output data register: DATA load plus optional atomic set/clear.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_data <= RESET_VAL;
      end else if (w_wr) begin
         case (address)
            ADDR_DATA:  r_data <= w_wd_data;
`ifdef IOT_OUTPUT_PIO_BITSET_EN
            ADDR_SET:   r_data <= r_data | w_wd_data;
            ADDR_CLEAR: r_data <= r_data & ~w_wd_data;
`endif
            default:    r_data <= r_data;
         endcase
      end
   end

   // Pulse length; a write during a pulse only affects the next one.
   always_ff @(posedge clk) begin
      if (!reset_n)                          r_plen <= '0;
      else if (w_wr && address == ADDR_PLEN) r_plen <= w_wd_cnt;
   end

   // Active inversion mask: captured on start, cleared on the last pulse cycle.
   always_ff @(posedge clk) begin
      if (!reset_n)    r_mask <= '0;
      else if (w_start) r_mask <= w_wd_data;
      else if (w_done)  r_mask <= '0;
   end

   iot_pulse_timer #(.CNT_W(CNT_W)) u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .i_start (w_start),
      .i_len   (r_plen),
      .o_busy  (w_busy),
      .o_done  (w_done)
   );

   // Zero-latency read mux, zero-extended; write-only and reserved read 0.
   always_comb begin
      w_rd = '0;
      case (address)
         ADDR_DATA: w_rd[DATA_W-1:0] = r_data;
         ADDR_PLEN: w_rd[CNT_W-1:0]  = r_plen;
         ADDR_TRIG: w_rd[DATA_W-1:0] = r_mask;
         ADDR_STAT: w_rd[0]          = w_busy;
         default:   w_rd             = '0;
      endcase
   end

   assign readdata   = w_rd;
   assign out_port   = r_data ^ r_mask;
   assign pulse_busy = w_busy;

endmodule

// File: tb/tb_iot_output_pio.sv
// Scoreboard bench for iot_output_pio: the driver updates a register-level
// model on every bus cycle and queues the expected outputs; a monitor pops
// and compares them just after each rising edge.
module tb_iot_output_pio;

   localparam int DW = 4;
   localparam int CW = 8;
   localparam logic [DW-1:0] RV = 4'hA;
`ifdef IOT_OUTPUT_PIO_BITSET_EN
   localparam bit BITSET = 1'b1;
`else
   localparam bit BITSET = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [2:0]    address = '0;
   logic          chipselect = 1'b0;
   logic          write_n = 1'b1;
   logic [31:0]   writedata = '0;
   logic [31:0]   readdata;
   logic [DW-1:0] out_port;
   logic          pulse_busy;

   iot_output_pio #(.DATA_W(DW), .CNT_W(CW), .RESET_VAL(RV)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_port   (out_port),
      .pulse_busy (pulse_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] out;
      logic          busy;
      logic [31:0]   rd;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Model state: register contents plus remaining inversion cycles.
   logic [DW-1:0] m_data = '0;
   logic [CW-1:0] m_plen = '0;
   logic [DW-1:0] m_mask = '0;
   int            m_rem  = 0;

   function automatic logic [31:0] m_read(input logic [2:0] a);
      case (a)
         3'd0: return {28'd0, m_data};
         3'd3: return {24'd0, m_plen};
         3'd4: return {28'd0, m_mask};
         3'd5: return {31'd0, (m_rem != 0)};
         default: return 32'd0;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One bus cycle: drive at negedge, advance the model across the next edge.
   task automatic step(input logic rst, input logic cs, input logic wn,
                       input logic [2:0] a, input logic [31:0] wd);
      bit            wr;
      bit            busy_pre;
      logic [CW-1:0] plen_pre;
      exp_t          e;
      @(negedge clk);
      reset_n = ~rst; chipselect = cs; write_n = wn; address = a; writedata = wd;
      wr       = cs && !wn;
      busy_pre = (m_rem != 0);
      plen_pre = m_plen;
      if (rst) begin
         m_data = RV; m_plen = '0; m_mask = '0; m_rem = 0;
      end else begin
         if (wr) begin
            case (a)
               3'd0: m_data = wd[DW-1:0];
               3'd1: if (BITSET) m_data = m_data | wd[DW-1:0];
               3'd2: if (BITSET) m_data = m_data & ~wd[DW-1:0];
               3'd3: m_plen = wd[CW-1:0];
               default: ;
            endcase
         end
         if (busy_pre) begin
            m_rem--;
            if (m_rem == 0) m_mask = '0;
         end else if (wr && a == 3'd4 && wd[DW-1:0] != '0) begin
            m_mask = wd[DW-1:0];
            m_rem  = (plen_pre == '0) ? 1 : int'(plen_pre);
         end
      end
      e.out  = m_data ^ m_mask;
      e.busy = (m_rem != 0);
      e.rd   = m_read(a);
      q.push_back(e);
   endtask

   task automatic wr_reg(input logic [2:0] a, input logic [31:0] wd);
      step(1'b0, 1'b1, 1'b0, a, wd);
   endtask

   task automatic rd_reg(input logic [2:0] a);
      step(1'b0, 1'b1, 1'b1, a, 32'd0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 3'd5, 32'hFFFF_FFFF);
   endtask

   // Monitor: outputs are checked every cycle the scoreboard has an entry.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            check("out_port", {28'd0, out_port}, {28'd0, e.out});
            check("pulse_busy", {31'd0, pulse_busy}, {31'd0, e.busy});
            check("readdata", readdata, e.rd);
         end
      end
   end

   initial begin
      logic [31:0] wd;
      logic [2:0]  a;
      // Reset and post-reset register reads
      step(1'b1, 1'b0, 1'b1, 3'd0, 32'd0);
      step(1'b1, 1'b0, 1'b1, 3'd0, 32'd0);
      rd_reg(3'd3); rd_reg(3'd4); rd_reg(3'd5); rd_reg(3'd0);
      // DATA / SET / CLEAR, then read write-only addresses
      wr_reg(3'd0, 32'hFFFF_FFF5);
      wr_reg(3'd1, 32'h2);
      wr_reg(3'd2, 32'h4);
      rd_reg(3'd1); rd_reg(3'd2); rd_reg(3'd6); rd_reg(3'd7);
      // Three-cycle pulse with mask 0x9 over zero data
      wr_reg(3'd3, 32'd3);
      wr_reg(3'd0, 32'd0);
      wr_reg(3'd4, 32'h9);
      idle(5);
      // Zero length gives a single-cycle pulse
      wr_reg(3'd3, 32'd0);
      wr_reg(3'd4, 32'h1);
      idle(3);
      // Trigger mid-pulse is ignored; new length applies to the next pulse
      wr_reg(3'd3, 32'd4);
      wr_reg(3'd4, 32'h1);
      idle(1);
      wr_reg(3'd3, 32'd5);
      wr_reg(3'd4, 32'h2);
      idle(4);
      wr_reg(3'd4, 32'h2);
      idle(7);
      // Zero-mask trigger does nothing
      wr_reg(3'd4, 32'h10);
      idle(2);
      // DATA write mid-pulse
      wr_reg(3'd4, 32'h3);
      wr_reg(3'd0, 32'hF);
      idle(6);
      // Reset aborts a long pulse
      wr_reg(3'd3, 32'd100);
      wr_reg(3'd4, 32'h5);
      idle(3);
      step(1'b1, 1'b0, 1'b1, 3'd4, 32'd0);
      rd_reg(3'd4);
      rd_reg(3'd3);
      // SET of all ones (no effect unless set/clear is built)
      wr_reg(3'd1, 32'hF);
      wr_reg(3'd2, 32'h1);
      rd_reg(3'd0);
      // Maximum pulse length register value
      wr_reg(3'd3, 32'h0000_00FF);
      rd_reg(3'd3);
      step(1'b0, 1'b1, 1'b1, 3'd3, 32'd0);
      wr_reg(3'd3, 32'd2);
      // Randomized traffic; short pulse lengths keep many pulses in flight
      for (int i = 0; i < 800; i++) begin
         a  = 3'($urandom_range(0, 7));
         wd = $urandom;
         if (a == 3'd3) wd[7:3] = 5'd0;
         step(($urandom_range(0, 99) == 0), 1'($urandom), 1'($urandom), a, wd);
      end
      idle(12);
      repeat (3) @(negedge clk);
      check("scoreboard_drained", 32'(q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/iot_output_pio.md
Name: iot_output_pio

Overview:
- Parametrised successor to the fixed 4-bit IoT output PIO: Avalon-MM slave driving a DATA_W-bit output port.
- Adds atomic bit set/clear registers and a timed one-shot pulse engine that inverts selected bits for a programmable number of clocks.
- Sits between the Nios II data master (via interconnect) and board LEDs/relays.
- Read latency 0: readdata is combinational from address, as in existing PIO slaves.

Parameters:
- DATA_W, 4, output port width (1..32).
- CNT_W, 16, pulse length counter width (1..32).
- RESET_VAL, 0, reset value of DATA register (DATA_W bits).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset; one clock; reset is synchronous and active-low.
- address  in  3  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data; bits above DATA_W/CNT_W ignored.
- readdata  out  32  read data, zero-extended.
- out_port  out  DATA_W  driven output = data_reg XOR pulse_mask_active.
- pulse_busy  out  1  high while a pulse is running.

Behaviour:
- Write strobe wr = chipselect & ~write_n; all registers update on clk rising edge.
- Register map (address: name, access):
  - 0: DATA, RW; write loads data_reg.
  - 1: SET, W; data_reg |= wdata; reads 0.
  - 2: CLEAR, W; data_reg &= ~wdata; reads 0.
  - 3: PULSE_LEN, RW, CNT_W bits.
  - 4: TRIGGER, W (mask); read returns pulse_mask_active.
  - 5: STATUS, RO; bit0 = pulse_busy.
  - 6-7: reserved; read 0, writes ignored.
- Reset (reset_n low at edge):
  - data_reg=RESET_VAL; pulse_len=0; pulse_mask_active=0; counter=0; FSM=IDLE.
  - Outputs: out_port=RESET_VAL, pulse_busy=0.
  - Reset mid-pulse aborts the pulse immediately.
- FSM IDLE:
  - TRIGGER write with nonzero mask: pulse_mask_active=wdata[DATA_W-1:0]; counter=max(pulse_len,1)-1; go PULSE.
  - Zero mask: stay IDLE.
- FSM PULSE:
  - pulse_busy=1. Counter decrements each clk.
  - When counter==0 at the edge: mask cleared, go IDLE.
  - Inversion therefore lasts exactly max(pulse_len,1) cycles, starting the cycle after the trigger write.
- TRIGGER write while PULSE: ignored (no restart, no mask change).
- PULSE_LEN write while PULSE: stored; affects next pulse only.
- DATA/SET/CLEAR during PULSE: data_reg updates normally; out_port reflects new data XOR active mask.
- SET and CLEAR are distinct addresses, so they never coincide. DATA write is last-writer per cycle (one access per cycle).
- Counter wrap: pulse_len=2^CNT_W-1 is the maximum; no wrap below 0.
- readdata: {zero-pad, selected register}; no side effects on read.

Optional Feature:
- Macro IOT_OUTPUT_PIO_BITSET_EN.
- Defined: SET/CLEAR at addresses 1/2 behave as above.
- Undefined: addresses 1/2 act as reserved (write ignored, read 0), and the set/clear logic is not built.
- DATA, pulse and status behaviour are identical in both cases.

Decomposition:
- Package iot_output_pkg holds:
  - address constants: ADDR_DATA=0, ADDR_SET=1, ADDR_CLEAR=2, ADDR_PLEN=3, ADDR_TRIG=4, ADDR_STAT=5;
  - FSM state typedef pulse_state_t {IDLE, PULSE}.
- One natural sub-module: iot_pulse_timer (CNT_W-bit load/decrement counter with busy and done), instantiated once.

Test Plan:
- Reset: hold reset_n=0 for 2 clks with RESET_VAL=4'hA -> out_port=4'hA, pulse_busy=0, all reads of addr 3/4/5 = 0.
- Write DATA=0x5, SET=0x2, CLEAR=0x4 (DATA_W=4) -> out_port 0x5, 0x7, 0x3 on successive cycles; read addr1/2 = 0.
- PULSE_LEN=3, data=0x0, TRIGGER=0x9 -> out_port=0x9 for exactly 3 cycles after the write cycle, then 0x0; pulse_busy high for the same 3 cycles.
- PULSE_LEN=0, TRIGGER=0x1 -> single-cycle inversion. Then PULSE_LEN=5 with a second TRIGGER=0x2 issued 2 cycles into the pulse -> the second trigger is ignored; the next trigger uses length 5.
- DATA=0xF written mid-pulse with mask 0x3 -> out_port=0xC until the pulse ends, then 0xF.
- reset_n=0 during a PULSE_LEN=100 pulse -> next cycle out_port=RESET_VAL, pulse_busy=0; build without IOT_OUTPUT_PIO_BITSET_EN -> SET write 0xF leaves out_port unchanged.
